// File: rtl/vx_dvg_stack.sv
// vx_dvg_stack: per-warp IPDOM divergence stack with a registered valid/ready response.
// Define VX_DVG_STACK_PERF_EN to add the divergent-split and peak-sp counters.
module vx_dvg_stack #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int DEPTH       = 8,
  parameter int PC_WIDTH    = 32,
  localparam int SPW = $clog2(DEPTH + 1),
  localparam int WW  = $clog2(NUM_WARPS)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [WW-1:0]          req_wid_i,
  input  logic [1:0]             req_op_i,
  input  logic [NUM_THREADS-1:0] req_tmask_i,
  input  logic [NUM_THREADS-1:0] req_then_tmask_i,
  input  logic [NUM_THREADS-1:0] req_else_tmask_i,
  input  logic [PC_WIDTH-1:0]    req_next_pc_i,
  input  logic [SPW-1:0]         req_join_sp_i,
  input  logic [WW-1:0]          peek_wid_i,
  output logic [SPW-1:0]         peek_sp_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [WW-1:0]          rsp_wid_o,
  output logic [NUM_THREADS-1:0] rsp_tmask_o,
  output logic                   rsp_jump_o,
  output logic [PC_WIDTH-1:0]    rsp_pc_o,
  output logic [SPW-1:0]         rsp_sp_o,
  output logic                   err_ovf_o,
  output logic                   err_unf_o
`ifdef VX_DVG_STACK_PERF_EN
  ,
  output logic [31:0]            perf_dvg_splits_o,
  output logic [SPW-1:0]         perf_max_sp_o
`endif
);
  localparam int EW = NUM_THREADS + PC_WIDTH + 1;
  localparam int AW = $clog2(NUM_WARPS * DEPTH);
  localparam logic [1:0] OP_SPLIT = 2'd0, OP_JOIN = 2'd1, OP_CLEAR = 2'd2;

  logic [SPW-1:0]         sp_q [NUM_WARPS];
  logic [SPW-1:0]         sp_d [NUM_WARPS];
  logic [EW-1:0]          ent_q [NUM_WARPS*DEPTH];
  logic                   rsp_valid_q, rsp_jump_q, err_ovf_q, err_unf_q;
  logic [WW-1:0]          rsp_wid_q;
  logic [NUM_THREADS-1:0] rsp_tmask_q, tmask_d;
  logic [PC_WIDTH-1:0]    rsp_pc_q, pc_d;
  logic [SPW-1:0]         rsp_sp_q, sp_cur;
  logic                   acc, div, fits, is_split, is_join, push, pop, ovf, unf, jump_d;
  logic [AW-1:0]          wa, ra;
  logic [EW-1:0]          top;

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign acc         = req_valid_i && req_ready_o;
  assign sp_cur      = sp_q[req_wid_i];
  assign div         = |req_then_tmask_i && |req_else_tmask_i;
  assign fits        = sp_cur <= SPW'(DEPTH - 2);
  assign is_split    = acc && req_op_i == OP_SPLIT;
  assign is_join     = acc && req_op_i == OP_JOIN && req_join_sp_i != sp_cur;
  assign push        = is_split && div && fits;
  assign ovf         = is_split && div && !fits;
  assign pop         = is_join && sp_cur != '0;
  assign unf         = is_join && sp_cur == '0;
  // wa is the first free slot of this warp's stack; ra is its top entry
  assign wa          = AW'(req_wid_i) * AW'(DEPTH) + AW'(sp_cur);
  assign ra          = wa - AW'(1);
  assign top         = ent_q[ra];
  assign tmask_d     = push ? req_then_tmask_i
                     : pop ? top[EW-1 -: NUM_THREADS]
                     : (is_split && !div) ? (|req_then_tmask_i ? req_then_tmask_i
                                          : |req_else_tmask_i ? req_else_tmask_i : req_tmask_i)
                     : req_tmask_i;
  assign jump_d      = pop && top[0];
  assign pc_d        = pop ? top[PC_WIDTH:1] : '0;

  always_comb begin
    sp_d            = sp_q;
    sp_d[req_wid_i] = push ? sp_cur + SPW'(2)
                    : pop ? sp_cur - SPW'(1)
                    : (acc && req_op_i == OP_CLEAR) ? '0 : sp_cur;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sp_q        <= '{default: '0};
      rsp_valid_q <= 1'b0;
      rsp_wid_q   <= '0;
      rsp_tmask_q <= '0;
      rsp_jump_q  <= 1'b0;
      rsp_pc_q    <= '0;
      rsp_sp_q    <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      err_ovf_q <= err_ovf_q | ovf;
      err_unf_q <= err_unf_q | unf;
      if (acc) begin
        rsp_valid_q <= 1'b1;
        rsp_wid_q   <= req_wid_i;
        rsp_tmask_q <= tmask_d;
        rsp_jump_q  <= jump_d;
        rsp_pc_q    <= pc_d;
        rsp_sp_q    <= sp_cur;
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Entry storage is deliberately not reset; sp alone defines validity
  always_ff @(posedge clk_i) begin
    if (push) begin
      ent_q[wa]          <= {req_tmask_i, {PC_WIDTH{1'b0}}, 1'b0};
      ent_q[wa + AW'(1)] <= {req_else_tmask_i, req_next_pc_i, 1'b1};
    end
  end

  assign peek_sp_o   = sp_q[peek_wid_i];
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_wid_o   = rsp_wid_q;
  assign rsp_tmask_o = rsp_tmask_q;
  assign rsp_jump_o  = rsp_jump_q;
  assign rsp_pc_o    = rsp_pc_q;
  assign rsp_sp_o    = rsp_sp_q;
  assign err_ovf_o   = err_ovf_q;
  assign err_unf_o   = err_unf_q;

`ifdef VX_DVG_STACK_PERF_EN
  logic [31:0]    perf_splits_q;
  logic [SPW-1:0] perf_max_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_splits_q <= '0;
      perf_max_q    <= '0;
    end else begin
      if (push && perf_splits_q != '1) perf_splits_q <= perf_splits_q + 32'd1;
      if (push && sp_d[req_wid_i] > perf_max_q) perf_max_q <= sp_d[req_wid_i];
    end
  end
  assign perf_dvg_splits_o = perf_splits_q;
  assign perf_max_sp_o     = perf_max_q;
`endif
endmodule

// File: tb/tb_vx_dvg_stack.sv
// tb_vx_dvg_stack: vector table plus scoreboard bench for vx_dvg_stack.
module tb_vx_dvg_stack;
  localparam int NW = 4, NT = 4, D = 8, PW = 32, SPW = 4, WW = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, rsp_jump, err_ovf, err_unf;
  logic [WW-1:0] req_wid = '0, peek_wid = '0, rsp_wid;
  logic [1:0] req_op = '0;
  logic [NT-1:0] req_tmask = '0, req_then = '0, req_else = '0, rsp_tmask;
  logic [PW-1:0] req_pc = '0, rsp_pc;
  logic [SPW-1:0] req_jsp = '0, peek_sp, rsp_sp;
`ifdef VX_DVG_STACK_PERF_EN
  logic [31:0] perf_splits;
  logic [SPW-1:0] perf_max;
`endif

  vx_dvg_stack #(.NUM_WARPS(NW), .NUM_THREADS(NT), .DEPTH(D), .PC_WIDTH(PW)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_wid_i(req_wid), .req_op_i(req_op), .req_tmask_i(req_tmask),
    .req_then_tmask_i(req_then), .req_else_tmask_i(req_else), .req_next_pc_i(req_pc),
    .req_join_sp_i(req_jsp), .peek_wid_i(peek_wid), .peek_sp_o(peek_sp),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_wid_o(rsp_wid),
    .rsp_tmask_o(rsp_tmask), .rsp_jump_o(rsp_jump), .rsp_pc_o(rsp_pc), .rsp_sp_o(rsp_sp),
    .err_ovf_o(err_ovf), .err_unf_o(err_unf)
`ifdef VX_DVG_STACK_PERF_EN
    , .perf_dvg_splits_o(perf_splits), .perf_max_sp_o(perf_max)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] wid; logic [1:0] op;
    logic [NT-1:0] tm, th, el; logic [PW-1:0] pc; logic [SPW-1:0] jsp;
    logic [NT-1:0] e_tm; logic e_jump; logic [PW-1:0] e_pc; logic [SPW-1:0] e_sp, e_peek;
  } vec_t;
  typedef struct packed {
    logic [WW-1:0] wid; logic [NT-1:0] tm; logic jump; logic [PW-1:0] pc; logic [SPW-1:0] sp;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[18];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic drive(input vec_t v);
    req_wid = v.wid; req_op = v.op; req_tmask = v.tm; req_then = v.th;
    req_else = v.el; req_pc = v.pc; req_jsp = v.jsp; req_valid = 1'b1;
  endtask

  function automatic exp_t exp_of(input vec_t v);
    return '{wid: v.wid, tm: v.e_tm, jump: v.e_jump, pc: v.e_pc, sp: v.e_sp};
  endfunction

  task automatic send(input vec_t v, input bit expect_rsp);
    int n = 0;
    @(posedge clk); #1;
    drive(v);
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n == 100) begin errors++; checks++; $display("FAIL req_ready timeout: got 0 expected 1"); end
    if (expect_rsp) sb.push_back(exp_of(v));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got tmask %0h expected no response", rsp_tmask);
      end else begin
        e = sb.pop_front();
        chk("rsp_wid", 32'(rsp_wid), 32'(e.wid));
        chk("rsp_tmask", 32'(rsp_tmask), 32'(e.tm));
        chk("rsp_jump", 32'(rsp_jump), 32'(e.jump));
        if (e.jump) chk("rsp_pc", rsp_pc, e.pc);
        chk("rsp_sp", 32'(rsp_sp), 32'(e.sp));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          wid op tm th el pc        jsp  e_tm jmp e_pc      e_sp peek
    tbl[0]  = '{0, 0, 4'hF, 4'h3, 4'hC, 32'h100, 4'd0, 4'h3, 1'b0, 32'h0,   4'd0, 4'd2};
    tbl[1]  = '{0, 1, 4'hF, 4'h0, 4'h0, 32'h0,   4'd0, 4'hC, 1'b1, 32'h100, 4'd2, 4'd1};
    tbl[2]  = '{0, 1, 4'hF, 4'h0, 4'h0, 32'h0,   4'd0, 4'hF, 1'b0, 32'h0,   4'd1, 4'd0};
    tbl[3]  = '{1, 0, 4'hF, 4'h3, 4'hC, 32'h200, 4'd0, 4'h3, 1'b0, 32'h0,   4'd0, 4'd2};
    tbl[4]  = '{1, 0, 4'h3, 4'h1, 4'h2, 32'h204, 4'd0, 4'h1, 1'b0, 32'h0,   4'd2, 4'd4};
    tbl[5]  = '{1, 0, 4'h3, 4'h1, 4'h2, 32'h208, 4'd0, 4'h1, 1'b0, 32'h0,   4'd4, 4'd6};
    tbl[6]  = '{1, 0, 4'h3, 4'h1, 4'h2, 32'h20C, 4'd0, 4'h1, 1'b0, 32'h0,   4'd6, 4'd8};
    tbl[7]  = '{1, 0, 4'h3, 4'h1, 4'h2, 32'h210, 4'd0, 4'h3, 1'b0, 32'h0,   4'd8, 4'd8};
    tbl[8]  = '{2, 0, 4'hF, 4'hF, 4'h0, 32'h0,   4'd0, 4'hF, 1'b0, 32'h0,   4'd0, 4'd0};
    tbl[9]  = '{2, 0, 4'hF, 4'h0, 4'h5, 32'h0,   4'd0, 4'h5, 1'b0, 32'h0,   4'd0, 4'd0};
    tbl[10] = '{2, 0, 4'h7, 4'h0, 4'h0, 32'h0,   4'd0, 4'h7, 1'b0, 32'h0,   4'd0, 4'd0};
    tbl[11] = '{3, 1, 4'h6, 4'h0, 4'h0, 32'h0,   4'd1, 4'h6, 1'b0, 32'h0,   4'd0, 4'd0};
    tbl[12] = '{1, 1, 4'h9, 4'h0, 4'h0, 32'h0,   4'd8, 4'h9, 1'b0, 32'h0,   4'd8, 4'd8};
    tbl[13] = '{1, 1, 4'h9, 4'h0, 4'h0, 32'h0,   4'd0, 4'h2, 1'b1, 32'h20C, 4'd8, 4'd7};
    tbl[14] = '{1, 1, 4'h9, 4'h0, 4'h0, 32'h0,   4'd0, 4'h3, 1'b0, 32'h0,   4'd7, 4'd6};
    tbl[15] = '{1, 3, 4'h5, 4'h0, 4'h0, 32'h0,   4'd0, 4'h5, 1'b0, 32'h0,   4'd6, 4'd6};
    tbl[16] = '{1, 2, 4'hA, 4'h0, 4'h0, 32'h0,   4'd0, 4'hA, 1'b0, 32'h0,   4'd6, 4'd0};
    tbl[17] = '{1, 1, 4'hB, 4'h0, 4'h0, 32'h0,   4'd3, 4'hB, 1'b0, 32'h0,   4'd0, 4'd0};

    #12;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_err_ovf", 32'(err_ovf), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("req_ready_idle", 32'(req_ready), 1);
    for (int w = 0; w < NW; w++) begin
      peek_wid = WW'(w); #1;
      chk("reset_peek_sp", 32'(peek_sp), 0);
    end

    for (int i = 0; i < 18; i++) begin
      send(tbl[i], 1'b1);
      peek_wid = tbl[i].wid; #1;
      chk($sformatf("peek_sp_v%0d", i), 32'(peek_sp), 32'(tbl[i].e_peek));
      if (i == 6) chk("err_ovf_before", 32'(err_ovf), 0);
      if (i == 7) chk("err_ovf_after", 32'(err_ovf), 1);
      if (i == 10) chk("err_unf_before", 32'(err_unf), 0);
      if (i == 11) chk("err_unf_after", 32'(err_unf), 1);
      if (i == 8) begin peek_wid = 2'd1; #1; chk("peek_w1_indep", 32'(peek_sp), 8); end
    end
    peek_wid = 2'd0; #1;
    chk("peek_w0_indep", 32'(peek_sp), 0);

    // backpressure: response held while requests queue behind it
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    v = '{0, 0, 4'hF, 4'h3, 4'hC, 32'h300, 4'd0, 4'h3, 1'b0, 32'h0, 4'd0, 4'd2};
    drive(v); sb.push_back(exp_of(v));
    @(posedge clk); #1;
    v = '{0, 1, 4'hF, 4'h0, 4'h0, 32'h0, 4'd0, 4'hC, 1'b1, 32'h300, 4'd2, 4'd1};
    drive(v); sb.push_back(exp_of(v));
    for (int c = 0; c < 3; c++) begin
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_tmask", 32'(rsp_tmask), 3);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    v = '{0, 1, 4'hF, 4'h0, 4'h0, 32'h0, 4'd0, 4'hF, 1'b0, 32'h0, 4'd1, 4'd0};
    drive(v); sb.push_back(exp_of(v));
    chk("bp_b_valid", 32'(rsp_valid), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_c_valid", 32'(rsp_valid), 1);
    @(posedge clk); #1;
    chk("bp_drained", 32'(rsp_valid), 0);
    chk("bp_sb_empty", sb.size(), 0);

    // reset with a pending response and sp(0)=4
    send('{0, 0, 4'hF, 4'h3, 4'hC, 32'h400, 4'd0, 4'h3, 1'b0, 32'h0, 4'd0, 4'd2}, 1'b1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive('{0, 0, 4'hF, 4'h3, 4'hC, 32'h500, 4'd0, 4'h3, 1'b0, 32'h0, 4'd2, 4'd4});
    @(posedge clk); #1;
    req_valid = 1'b0;
    peek_wid = 2'd0; #1;
    chk("pre_reset_valid", 32'(rsp_valid), 1);
    chk("pre_reset_peek", 32'(peek_sp), 4);
    #1 reset = 1'b1;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 0);
    chk("async_rsp_tmask", 32'(rsp_tmask), 0);
    chk("async_rsp_sp", 32'(rsp_sp), 0);
    chk("async_err_ovf", 32'(err_ovf), 0);
    chk("async_err_unf", 32'(err_unf), 0);
    for (int w = 0; w < NW; w++) begin
      peek_wid = WW'(w); #1;
      chk("async_peek_sp", 32'(peek_sp), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    send(tbl[0], 1'b1);
    peek_wid = 2'd0; #1;
    chk("post_reset_peek", 32'(peek_sp), 2);
    @(posedge clk); #1;
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
